piso_bit_serializer: RTL

//   Parallel-in/serial-out stage that feeds the serial "101" Moore sequence detector.

---
 rtl/piso_bit_serializer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer
// Parallel-in/serial-out stage feeding a serial "101" sequence detector.
// A WIDTH-bit word is accepted via load_valid/load_ready while idle. Its bits
// are then sent on bit_out, with each bit held for DIV clocks. bit_valid marks
// the first cycle of every bit. frame_start and frame_done bracket the word.
// bit_out is driven low whenever no word is being sent, so the detector only
// sees zeros between frames.
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;

  // The bit that leaves first from a given word, depending on shift direction.
  function automatic logic lead_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  // Shift register contents after moving on to the next bit.
  always_comb begin
    shreg_shifted = shreg_q;
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Next-state and registered-output computation for the IDLE/SEND/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    div_cnt_d     = div_cnt_q;
    bit_out_d     = bit_out_q;
    bit_valid_d   = 1'b0;
    busy_d        = busy_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        bit_out_d = 1'b0;
        busy_d    = 1'b0;
        if (load_valid) begin
          state_d       = SEND;
          shreg_d       = load_data;
          bit_cnt_d     = '0;
          div_cnt_d     = '0;
          bit_out_d     = lead_bit(load_data);
          bit_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
        end
      end
      SEND: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == CNT_LAST) begin
            state_d      = DONE;
            bit_cnt_d    = '0;
            busy_d       = 1'b0;
            bit_out_d    = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            shreg_d     = shreg_shifted;
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
            bit_out_d   = lead_bit(shreg_shifted);
            bit_valid_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        bit_out_d = 1'b0;
        busy_d    = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        bit_out_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign busy        = busy_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;

endmodule
